wb_project_mux: RTL and testbench

Parametrised successor to the single-project wrapper: one Caravel user-area slot shared by `N_PROJ` user projects. A register-selected project gets the Wishbone bus, IO pads and IRQs. All other projects see an idle bus and have their outputs discarded. Wishbone forwarding is registered and guarded by a timeout watchdog, so a hung project can never stall the management SoC.

---
 rtl/wb_project_mux.sv | 205 ++++++++++++++++++++
 tb/tb_wb_project_mux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_project_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_project_mux
//  Purpose  : Shares one Wishbone user slot between N_PROJ projects. A
//             register-selected project receives the bus, pads and IRQs.
//             Forwarded accesses are registered and bounded by a watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_project_mux #(
    parameter int          N_PROJ   = 4,
    parameter int          IO_PADS  = 38,
    parameter logic [31:0] CFG_BASE = 32'h3000_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [N_PROJ-1:0]         proj_cyc_o,
    output logic [N_PROJ-1:0]         proj_stb_o,
    output logic                      proj_we_o,
    output logic [3:0]                proj_sel_o,
    output logic [31:0]               proj_adr_o,
    output logic [31:0]               proj_dat_o,
    input  logic [N_PROJ-1:0]         proj_ack_i,
    input  logic [N_PROJ*32-1:0]      proj_dat_i,
    input  logic [N_PROJ*IO_PADS-1:0] proj_io_out_i,
    input  logic [N_PROJ*IO_PADS-1:0] proj_io_oeb_i,
    input  logic [N_PROJ*3-1:0]       proj_irq_i,
    output logic [N_PROJ-1:0]         proj_active_o,
    output logic [IO_PADS-1:0]        io_out,
    output logic [IO_PADS-1:0]        io_oeb,
    output logic [2:0]                irq
);

    localparam int              WAIT_W       = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [8:0]      C_NPROJ      = 9'(N_PROJ);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCAL = 3'd1,
        ST_FWD   = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          sel_idx_q, sel_idx_d;
    logic                sel_en_q, sel_en_d;
    logic                to_flag_q, to_flag_d;
    logic [7:0]          to_cnt_q, to_cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;

    logic                sel_valid;
    logic [N_PROJ-1:0]   sel_onehot;
    logic                sel_ack;
    logic [31:0]         sel_rdata;
    logic                req;
    logic                in_window;
    logic [31:0]         sel_rd;
    logic [31:0]         status_rd;

    // Bits of the master bus that carry no meaning for this block
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[30:8]};

    // Broadcast copies of the master request to every project
    assign proj_we_o  = wbs_we_i;
    assign proj_sel_o = wbs_sel_i;
    assign proj_adr_o = wbs_adr_i;
    assign proj_dat_o = wbs_dat_i;

    assign req       = wbs_cyc_i && wbs_stb_i;
    assign in_window = (wbs_adr_i[31:3] == CFG_BASE[31:3]);
    assign sel_rd    = {sel_en_q, 23'd0, sel_idx_q};
    assign status_rd = {16'd0, to_cnt_q, 7'd0, to_flag_q};
    assign sel_valid = sel_en_q && ({1'b0, sel_idx_q} < C_NPROJ);

    // Decode the selected project and pick its pad, IRQ, ack and data slices
    always_comb begin
        sel_onehot = '0;
        io_out     = '0;
        io_oeb     = '1;
        irq        = '0;
        sel_ack    = 1'b0;
        sel_rdata  = '0;
        for (int p = 0; p < N_PROJ; p++) begin
            if (sel_valid && (sel_idx_q == 8'(p))) begin
                sel_onehot[p] = 1'b1;
                io_out        = proj_io_out_i[p*IO_PADS +: IO_PADS];
                io_oeb        = proj_io_oeb_i[p*IO_PADS +: IO_PADS];
                irq           = proj_irq_i[p*3 +: 3];
                sel_ack       = proj_ack_i[p];
                sel_rdata     = proj_dat_i[p*32 +: 32];
            end
        end
    end

    assign proj_active_o = sel_onehot;
    // Strobe follows the registered FWD state, so it drops the cycle FWD is left
    assign proj_cyc_o    = (state_q == ST_FWD) ? sel_onehot : '0;
    assign proj_stb_o    = (state_q == ST_FWD) ? sel_onehot : '0;
    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;

    // Next-state, register-file and response computation
    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        sel_en_d  = sel_en_q;
        to_flag_d = to_flag_q;
        to_cnt_d  = to_cnt_q;
        wait_d    = wait_q;
        ack_d     = 1'b0;
        dat_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (in_window) begin
                        // Local access completes on this edge; LOCAL is the ack cycle
                        state_d = ST_LOCAL;
                        ack_d   = 1'b1;
                        if (wbs_we_i) begin
                            if (!wbs_adr_i[2]) begin
                                sel_idx_d = wbs_dat_i[7:0];
                                sel_en_d  = wbs_dat_i[31];
                            end else if (wbs_dat_i[0]) begin
                                to_flag_d = 1'b0;
                                to_cnt_d  = '0;
                            end
                        end else begin
                            dat_d = wbs_adr_i[2] ? status_rd : sel_rd;
                        end
                    end else if (sel_valid) begin
                        state_d = ST_FWD;
                        wait_d  = '0;
                    end else begin
                        state_d = ST_ERR;
                        ack_d   = 1'b1;
                        dat_d   = wbs_we_i ? 32'd0 : ERR_DATA;
                    end
                end
            end
            ST_FWD: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    dat_d   = sel_rdata;
                end else if (wait_q == C_WAIT_LAST) begin
                    // This is the TIMEOUT-th strobe cycle without an ack
                    state_d   = ST_ERR;
                    ack_d     = 1'b1;
                    dat_d     = wbs_we_i ? 32'd0 : ERR_DATA;
                    to_flag_d = 1'b1;
                    to_cnt_d  = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_LOCAL, ST_RESP, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register storage with asynchronous active-low reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            sel_idx_q <= '0;
            sel_en_q  <= 1'b0;
            to_flag_q <= 1'b0;
            to_cnt_q  <= '0;
            wait_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            sel_en_q  <= sel_en_d;
            to_flag_q <= to_flag_d;
            to_cnt_q  <= to_cnt_d;
            wait_q    <= wait_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_project_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_project_mux
//  Purpose  : Directed self-checking bench for wb_project_mux
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_project_mux;

    localparam int          NP   = 4;
    localparam int          PADS = 38;
    localparam logic [31:0] A_SEL  = 32'h3000_0000;
    localparam logic [31:0] A_STAT = 32'h3000_0004;
    localparam logic [31:0] A_FWD  = 32'h3000_0100;

    logic                 wb_clk_i = 1'b0;
    logic                 wb_rst_n_i = 1'b0;
    logic                 wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]           wbs_sel_i = 4'hF;
    logic [31:0]          wbs_adr_i = '0, wbs_dat_i = '0;
    logic                 wbs_ack_o;
    logic [31:0]          wbs_dat_o;
    logic [NP-1:0]        proj_cyc_o, proj_stb_o;
    logic                 proj_we_o;
    logic [3:0]           proj_sel_o;
    logic [31:0]          proj_adr_o, proj_dat_o;
    logic [NP-1:0]        proj_ack_i = '0;
    logic [NP*32-1:0]     proj_dat_i;
    logic [NP*PADS-1:0]   proj_io_out_i, proj_io_oeb_i;
    logic [NP*3-1:0]      proj_irq_i;
    logic [NP-1:0]        proj_active_o;
    logic [PADS-1:0]      io_out, io_oeb;
    logic [2:0]           irq;

    int n_cmp = 0;
    int n_bad = 0;

    wb_project_mux #(
        .N_PROJ(NP), .IO_PADS(PADS), .CFG_BASE(32'h3000_0000),
        .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .proj_cyc_o(proj_cyc_o), .proj_stb_o(proj_stb_o), .proj_we_o(proj_we_o),
        .proj_sel_o(proj_sel_o), .proj_adr_o(proj_adr_o), .proj_dat_o(proj_dat_o),
        .proj_ack_i(proj_ack_i), .proj_dat_i(proj_dat_i),
        .proj_io_out_i(proj_io_out_i), .proj_io_oeb_i(proj_io_oeb_i),
        .proj_irq_i(proj_irq_i), .proj_active_o(proj_active_o),
        .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // One local register access; returns what the master saw in cycle 1
    task automatic bus_local(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             output logic ack, output logic [31:0] rd);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;
        @(posedge wb_clk_i); #1;
        ack = wbs_ack_o; rd = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic start_read(input logic [31:0] adr);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
    endtask

    task automatic stop_bus();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        logic a; logic [31:0] d;
        n_cmp++; if (proj_active_o !== 4'b0000) begin n_bad++; $display("FAIL rst_active got %b exp 0000", proj_active_o); end
        n_cmp++; if (io_oeb !== {PADS{1'b1}}) begin n_bad++; $display("FAIL rst_oeb got %h exp all ones", io_oeb); end
        n_cmp++; if (io_out !== '0 || irq !== 3'd0) begin n_bad++; $display("FAIL rst_io got %h/%h exp 0/0", io_out, irq); end
        n_cmp++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0 || proj_stb_o !== '0) begin
            n_bad++; $display("FAIL rst_bus got ack %b dat %h stb %b exp 0", wbs_ack_o, wbs_dat_o, proj_stb_o); end
        bus_local(1'b0, A_SEL, 32'd0, a, d);
        n_cmp++; if (a !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL rst_sel got ack %b dat %h exp 1/00000000", a, d); end
        bus_local(1'b0, A_STAT, 32'd0, a, d);
        n_cmp++; if (a !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL rst_status got ack %b dat %h exp 1/00000000", a, d); end
    endtask

    task automatic test_forward();
        logic a; logic [31:0] d;
        bus_local(1'b1, A_SEL, 32'h8000_0002, a, d);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL fwd_selwr got ack %b exp 1", a); end
        n_cmp++; if (proj_active_o !== 4'b0100) begin n_bad++; $display("FAIL fwd_active got %b exp 0100", proj_active_o); end
        n_cmp++; if (io_out !== 38'h02_A5A5_0002 || io_oeb !== 38'h3D_5A5A_FFFD) begin
            n_bad++; $display("FAIL fwd_io got %h/%h exp 02a5a50002/3d5a5afffd", io_out, io_oeb); end
        n_cmp++; if (irq !== 3'd3) begin n_bad++; $display("FAIL fwd_irq got %h exp 3", irq); end
        start_read(A_FWD);
        for (int c = 1; c <= 6; c++) begin
            @(posedge wb_clk_i); #1;
            if (c <= 4) begin
                n_cmp++; if (proj_stb_o !== 4'b0100 || proj_cyc_o !== 4'b0100 || wbs_ack_o !== 1'b0) begin
                    n_bad++; $display("FAIL fwd_wait%0d got stb %b ack %b exp 0100/0", c, proj_stb_o, wbs_ack_o); end
            end
            if (c == 4) begin
                proj_ack_i = 4'b0100;
                proj_dat_i[2*32 +: 32] = 32'h1234_5678;
            end
            if (c == 5) begin
                n_cmp++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h1234_5678) begin
                    n_bad++; $display("FAIL fwd_ack got ack %b dat %h exp 1/12345678", wbs_ack_o, wbs_dat_o); end
                proj_ack_i = '0;
                proj_dat_i[2*32 +: 32] = 32'h3333_3333;
                stop_bus();
            end
            if (c == 6) begin
                n_cmp++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0) begin
                    n_bad++; $display("FAIL fwd_after got ack %b dat %h exp 0/0", wbs_ack_o, wbs_dat_o); end
            end
        end
    endtask

    task automatic test_timeout();
        logic a; logic [31:0] d; logic got; int stb_cnt; int ack_cyc;
        bus_local(1'b1, A_SEL, 32'h8000_0001, a, d);
        start_read(A_FWD);
        got = 1'b0; stb_cnt = 0; ack_cyc = 0; d = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin got = 1'b1; ack_cyc = c; d = wbs_dat_o; end
            else if (proj_stb_o[1]) stb_cnt++;
        end
        stop_bus();
        @(posedge wb_clk_i); #1;
        n_cmp++; if (got !== 1'b1 || ack_cyc != 9) begin n_bad++; $display("FAIL to_ack got ack %b cycle %0d exp 1/9", got, ack_cyc); end
        n_cmp++; if (stb_cnt != 8) begin n_bad++; $display("FAIL to_strobe got %0d cycles exp 8", stb_cnt); end
        n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL to_data got %h exp deadbeef", d); end
        bus_local(1'b0, A_STAT, 32'd0, a, d);
        n_cmp++; if (d !== 32'h0000_0101) begin n_bad++; $display("FAIL to_status got %h exp 00000101", d); end
        bus_local(1'b1, A_STAT, 32'd1, a, d);
        bus_local(1'b0, A_STAT, 32'd0, a, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL to_clear got %h exp 00000000", d); end
    endtask

    task automatic test_unrouted();
        logic a; logic [31:0] d;
        bus_local(1'b1, A_SEL, 32'h8000_0009, a, d);
        bus_local(1'b0, A_SEL, 32'd0, a, d);
        n_cmp++; if (d !== 32'h8000_0009) begin n_bad++; $display("FAIL unr_readback got %h exp 80000009", d); end
        n_cmp++; if (proj_active_o !== 4'b0000 || io_oeb !== {PADS{1'b1}}) begin
            n_bad++; $display("FAIL unr_idle got %b/%h exp 0000/all ones", proj_active_o, io_oeb); end
        start_read(A_FWD);
        @(posedge wb_clk_i); #1;
        n_cmp++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hDEAD_BEEF || proj_stb_o !== 4'b0000) begin
            n_bad++; $display("FAIL unr_err got ack %b dat %h stb %b exp 1/deadbeef/0000", wbs_ack_o, wbs_dat_o, proj_stb_o); end
        stop_bus();
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_abort();
        logic a; logic [31:0] d;
        bus_local(1'b1, A_SEL, 32'h8000_0002, a, d);
        start_read(A_FWD);
        @(posedge wb_clk_i); #1;
        n_cmp++; if (proj_stb_o !== 4'b0100) begin n_bad++; $display("FAIL ab_stb got %b exp 0100", proj_stb_o); end
        stop_bus();
        for (int c = 0; c < 3; c++) begin
            @(posedge wb_clk_i); #1;
            n_cmp++; if (proj_stb_o !== 4'b0000 || wbs_ack_o !== 1'b0) begin
                n_bad++; $display("FAIL ab_drop%0d got stb %b ack %b exp 0000/0", c, proj_stb_o, wbs_ack_o); end
        end
        bus_local(1'b0, A_SEL, 32'd0, a, d);
        n_cmp++; if (a !== 1'b1 || d !== 32'h8000_0002) begin n_bad++; $display("FAIL ab_next got ack %b dat %h exp 1/80000002", a, d); end
        // Asynchronous reset in the middle of a forwarded access
        start_read(A_FWD);
        @(posedge wb_clk_i); #1;
        wb_rst_n_i = 1'b0;
        #1;
        n_cmp++; if (proj_stb_o !== 4'b0000 || wbs_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL ab_rst got stb %b ack %b exp 0000/0", proj_stb_o, wbs_ack_o); end
        stop_bus();
        @(posedge wb_clk_i); #1;
        wb_rst_n_i = 1'b1;
        @(posedge wb_clk_i); #1;
        n_cmp++; if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL ab_rst_ack got %b exp 0", wbs_ack_o); end
        bus_local(1'b0, A_SEL, 32'd0, a, d);
        n_cmp++; if (a !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL ab_rst_sel got ack %b dat %h exp 1/0", a, d); end
    endtask

    task automatic test_foreign_ack();
        logic a; logic [31:0] d;
        bus_local(1'b1, A_SEL, 32'h8000_0002, a, d);
        proj_ack_i = 4'b1011;
        start_read(A_FWD);
        for (int c = 1; c <= 4; c++) begin
            @(posedge wb_clk_i); #1;
            if (c <= 3) begin
                n_cmp++; if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL fa_ignore%0d got ack %b exp 0", c, wbs_ack_o); end
            end
            if (c == 3) proj_ack_i = 4'b1111;
            if (c == 4) begin
                n_cmp++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h3333_3333) begin
                    n_bad++; $display("FAIL fa_ack got ack %b dat %h exp 1/33333333", wbs_ack_o, wbs_dat_o); end
                proj_ack_i = '0;
                stop_bus();
            end
        end
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_back_to_back();
        start_read(A_SEL);
        @(posedge wb_clk_i); #1;
        n_cmp++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h8000_0002) begin
            n_bad++; $display("FAIL b2b_first got ack %b dat %h exp 1/80000002", wbs_ack_o, wbs_dat_o); end
        wbs_adr_i = A_STAT;
        @(posedge wb_clk_i); #1;
        n_cmp++; if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got ack %b exp 0", wbs_ack_o); end
        @(posedge wb_clk_i); #1;
        n_cmp++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'd0) begin
            n_bad++; $display("FAIL b2b_second got ack %b dat %h exp 1/0", wbs_ack_o, wbs_dat_o); end
        stop_bus();
        @(posedge wb_clk_i); #1;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            proj_dat_i[p*32 +: 32]      = 32'h1111_1111 * 32'(p + 1);
            proj_io_out_i[p*PADS +: PADS] = {6'(p), 32'hA5A5_0000 + 32'(p)};
            proj_io_oeb_i[p*PADS +: PADS] = ~{6'(p), 32'hA5A5_0000 + 32'(p)};
            proj_irq_i[p*3 +: 3]        = 3'(p + 1);
        end
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b1;
        @(posedge wb_clk_i); #1;
        test_reset();
        test_forward();
        test_timeout();
        test_unrouted();
        test_abort();
        test_foreign_ack();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
